// File: rtl/puf_enroll_sequencer_pkg.sv
// puf_pkg: shared definitions for the PUF enrollment sequencer and the
// readout logic that consumes its records.
//   - state_t   : sequencer FSM states
//   - DEF_*     : default challenge/response widths and sample count
//   - record_t  : {chal, resp, unstable} record at the default widths
package puf_pkg;

    localparam int DEF_CHAL_W  = 8;
    localparam int DEF_RESP_W  = 8;
    localparam int DEF_REPEATS = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_REL  = 3'd2,
        ST_EMIT = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    typedef struct packed {
        logic [DEF_CHAL_W-1:0] chal;
        logic [DEF_RESP_W-1:0] resp;
        logic [DEF_RESP_W-1:0] unstable;
    } record_t;

endpackage

// File: rtl/puf_enroll_sequencer_bit_voter.sv
// puf_bit_voter: per-bit vote counters for repeated PUF samples.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clr_i        : zero every counter (wins over acc_i)
//   acc_i        : add bits_i into the counters (vote[i] += bits_i[i])
//   bits_i       : one sampled response
//   maj_o        : majority mask, vote[i] > REPEATS/2
//   unstable_o   : 1 where the samples were not unanimous
// Counters never exceed REPEATS because the sequencer takes exactly REPEATS
// samples between clears, so no saturation logic is needed.
module puf_bit_voter #(
    parameter int RESP_W  = 8,
    parameter int REPEATS = 5,
    localparam int VCNT_W = $clog2(REPEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              acc_i,
    input  logic [RESP_W-1:0] bits_i,
    output logic [RESP_W-1:0] maj_o,
    output logic [RESP_W-1:0] unstable_o
);

    localparam logic [VCNT_W-1:0] HALF = VCNT_W'(REPEATS / 2);
    localparam logic [VCNT_W-1:0] FULL = VCNT_W'(REPEATS);

    logic [VCNT_W-1:0] vote_q [RESP_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RESP_W; i++) begin
                vote_q[i] <= '0;
            end
        end else if (clr_i) begin
            for (int i = 0; i < RESP_W; i++) begin
                vote_q[i] <= '0;
            end
        end else if (acc_i) begin
            for (int i = 0; i < RESP_W; i++) begin
                vote_q[i] <= vote_q[i] + VCNT_W'(bits_i[i]);
            end
        end
    end

    always_comb begin
        maj_o      = '0;
        unstable_o = '0;
        for (int i = 0; i < RESP_W; i++) begin
            maj_o[i]      = (vote_q[i] > HALF);
            unstable_o[i] = (vote_q[i] != '0) && (vote_q[i] != FULL);
        end
    end

endmodule

// File: rtl/puf_enroll_sequencer.sv
// puf_enroll_sequencer: drives a run of challenges into a PUF core over a
// four-phase req/ack handshake, samples each challenge REPEATS times,
// majority-votes the response and emits one {chal, resp, unstable} record
// per challenge on a valid/ready port.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, chal_base,
//   chal_count               : run request and operands (ignored while busy)
//   puf_req, puf_chal        : request and challenge to the PUF core
//   puf_ack, puf_resp        : PUF acknowledge and response (valid with ack)
//   out_valid, out_ready     : record handshake
//   out_chal, out_resp,
//   out_unstable             : record fields, held until accepted
//   busy, done               : run in progress, one-cycle end-of-run pulse
//   state_dbg                : current FSM state
// Handshakes: a record transfers on a rising edge where out_valid and
// out_ready are both 1; out_valid and the record fields never change while
// waiting. puf_req rises only after puf_ack has been seen low and falls only
// after puf_ack has been seen high; puf_chal is constant while puf_req=1.
module puf_enroll_sequencer
    import puf_pkg::*;
#(
    parameter int CHAL_W  = DEF_CHAL_W,
    parameter int RESP_W  = DEF_RESP_W,
    parameter int REPEATS = DEF_REPEATS,
    localparam int VCNT_W = $clog2(REPEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAL_W-1:0] chal_base,
    input  logic [CHAL_W-1:0] chal_count,
    output logic              puf_req,
    output logic [CHAL_W-1:0] puf_chal,
    input  logic              puf_ack,
    input  logic [RESP_W-1:0] puf_resp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CHAL_W-1:0] out_chal,
    output logic [RESP_W-1:0] out_resp,
    output logic [RESP_W-1:0] out_unstable,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam logic [CHAL_W-1:0] ONE_C     = CHAL_W'(1);
    localparam logic [VCNT_W-1:0] ONE_S     = VCNT_W'(1);
    localparam logic [VCNT_W-1:0] LAST_SAMP = VCNT_W'(REPEATS - 1);

    state_t            state_q, state_d;
    logic [CHAL_W-1:0] base_q, base_d;
    logic [CHAL_W-1:0] count_q, count_d;
    logic [CHAL_W-1:0] idx_q, idx_d;
    logic [VCNT_W-1:0] samp_q, samp_d;
    logic [CHAL_W-1:0] out_chal_q, out_chal_d;
    logic [RESP_W-1:0] out_resp_q, out_resp_d;
    logic [RESP_W-1:0] out_unst_q, out_unst_d;

    logic              vote_clr;
    logic              vote_acc;
    logic [RESP_W-1:0] vote_maj;
    logic [RESP_W-1:0] vote_unst;

    puf_bit_voter #(
        .RESP_W  (RESP_W),
        .REPEATS (REPEATS)
    ) u_voter (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (vote_clr),
        .acc_i      (vote_acc),
        .bits_i     (puf_resp),
        .maj_o      (vote_maj),
        .unstable_o (vote_unst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            samp_q     <= '0;
            out_chal_q <= '0;
            out_resp_q <= '0;
            out_unst_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            samp_q     <= samp_d;
            out_chal_q <= out_chal_d;
            out_resp_q <= out_resp_d;
            out_unst_q <= out_unst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        idx_d      = idx_q;
        samp_d     = samp_q;
        out_chal_d = out_chal_q;
        out_resp_d = out_resp_q;
        out_unst_d = out_unst_q;
        vote_clr   = 1'b0;
        vote_acc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = chal_base;
                    count_d  = chal_count;
                    idx_d    = '0;
                    samp_d   = '0;
                    vote_clr = 1'b1;
                    state_d  = (chal_count == '0) ? ST_FIN : ST_REQ;
                end
            end
            ST_REQ: begin
                if (puf_ack) begin
                    vote_acc = 1'b1;
                    state_d  = ST_REL;
                end
            end
            ST_REL: begin
                if (!puf_ack) begin
                    samp_d = samp_q + ONE_S;
                    if (samp_q == LAST_SAMP) begin
                        // Last sample is already in the counters: freeze the
                        // record now so it is stable for the whole EMIT stay.
                        out_chal_d = base_q + idx_q;
                        out_resp_d = vote_maj;
                        out_unst_d = vote_unst;
                        state_d    = ST_EMIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    vote_clr = 1'b1;
                    samp_d   = '0;
                    idx_d    = idx_q + ONE_C;
                    state_d  = ((idx_q + ONE_C) == count_q) ? ST_FIN : ST_REQ;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign puf_req      = (state_q == ST_REQ);
    assign puf_chal     = base_q + idx_q;
    assign out_valid    = (state_q == ST_EMIT);
    assign out_chal     = out_chal_q;
    assign out_resp     = out_resp_q;
    assign out_unstable = out_unst_q;
    assign busy         = (state_q == ST_REQ) || (state_q == ST_REL) || (state_q == ST_EMIT);
    assign done         = (state_q == ST_FIN);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_puf_enroll_sequencer.sv
module tb_puf_enroll_sequencer;

    localparam int CHAL_W  = 8;
    localparam int RESP_W  = 8;
    localparam int REPEATS = 5;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CHAL_W-1:0] chal_base;
    logic [CHAL_W-1:0] chal_count;
    logic              puf_req;
    logic [CHAL_W-1:0] puf_chal;
    logic              puf_ack;
    logic [RESP_W-1:0] puf_resp;
    logic              out_valid;
    logic              out_ready;
    logic [CHAL_W-1:0] out_chal;
    logic [RESP_W-1:0] out_resp;
    logic [RESP_W-1:0] out_unstable;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    always #5 clk = ~clk;

    puf_enroll_sequencer #(
        .CHAL_W  (CHAL_W),
        .RESP_W  (RESP_W),
        .REPEATS (REPEATS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .chal_base    (chal_base),
        .chal_count   (chal_count),
        .puf_req      (puf_req),
        .puf_chal     (puf_chal),
        .puf_ack      (puf_ack),
        .puf_resp     (puf_resp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_chal     (out_chal),
        .out_resp     (out_resp),
        .out_unstable (out_unstable),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [23:0] exp_q[$];   // {chal, resp, unstable} expected records
    logic [15:0] samp_q[$];  // {chal, resp} one entry per PUF handshake
    int n_vec    = 0;
    int n_err    = 0;
    int hs_cnt   = 0;
    int done_cnt = 0;
    int req_rise = 0;
    int dly_min  = 1;
    int dly_max  = 1;
    bit rand_ready = 1'b0;
    bit ready_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gen_resp(input int mode, input logic [7:0] c,
                                            input int s, input logic [7:0] nb);
        logic [7:0] m;
        m = 8'h00;
        case (mode)
            0: return c ^ 8'h5A;
            1: return 8'h80 | ((s < 3) ? 8'h01 : 8'h00);
            2: return 8'h80 | ((s < 2) ? 8'h01 : 8'h00);
            default: begin
                if ($urandom_range(0, 2) == 0) m = 8'h01 << $urandom_range(0, 7);
                return nb ^ m;
            end
        endcase
    endfunction

    // Generate every sample the PUF will return for a run and the record the
    // sequencer must produce for each challenge (bit-wise count of ones).
    task automatic build_run(input logic [7:0] base, input int count, input int mode);
        logic [7:0] c, r, nb, maj, unst;
        int ones[RESP_W];
        for (int i = 0; i < count; i++) begin
            c  = base + 8'(i);
            nb = 8'($urandom);
            for (int b = 0; b < RESP_W; b++) ones[b] = 0;
            for (int s = 0; s < REPEATS; s++) begin
                r = gen_resp(mode, c, s, nb);
                samp_q.push_back({c, r});
                for (int b = 0; b < RESP_W; b++) ones[b] += int'(r[b]);
            end
            for (int b = 0; b < RESP_W; b++) begin
                maj[b]  = (ones[b] > REPEATS / 2);
                unst[b] = (ones[b] != 0) && (ones[b] != REPEATS);
            end
            exp_q.push_back({c, maj, unst});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [7:0] base, input logic [7:0] count);
        @(negedge clk);
        chal_base  = base;
        chal_count = count;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        chal_base  = 8'($urandom);
        chal_count = 8'($urandom);
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (done_cnt == d0) fail_now({name, "_done_timeout"});
        repeat (3) begin
            @(negedge clk);
            #2;
        end
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_records_left"}, exp_q.size(), 0);
        check({name, "_busy_after"}, {31'd0, busy}, 0);
    endtask

    // ---------------- PUF core model ----------------
    initial begin : puf_model
        logic [15:0] ent;
        logic [7:0]  chal_seen;
        bit          drift;
        int          d;
        int          k;
        puf_ack  = 1'b0;
        puf_resp = '0;
        forever begin
            @(negedge clk);
            if (puf_req && !puf_ack) begin
                chal_seen = puf_chal;
                drift     = 1'b0;
                d = $urandom_range(dly_max, dly_min);
                repeat (d) begin
                    @(negedge clk);
                    if (puf_req && puf_chal !== chal_seen) drift = 1'b1;
                end
                if (samp_q.size() == 0) begin
                    fail_now("puf_unexpected_request");
                    puf_resp = 8'($urandom);
                end else begin
                    ent = samp_q.pop_front();
                    check("puf_chal", {24'd0, chal_seen}, {24'd0, ent[15:8]});
                    puf_resp = ent[7:0];
                end
                puf_ack = 1'b1;
                hs_cnt++;
                k = 0;
                while (puf_req && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                if (puf_req) fail_now("puf_req_never_released");
                check("puf_chal_stable", {31'd0, drift}, 0);
                d = $urandom_range(dly_max, dly_min);
                repeat (d) @(negedge clk);
                puf_ack  = 1'b0;
                puf_resp = 8'($urandom);
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_hold)      out_ready = 1'b0;
            else if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            else                 out_ready = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                req_prev = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (puf_req && !req_prev) begin
                    req_rise++;
                    if (puf_ack) fail_now("req_raised_while_ack_high");
                end
                req_prev = puf_req;
                if (out_valid && puf_req) fail_now("req_during_emit");
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_record");
                    else check("record", {8'd0, out_chal, out_resp, out_unstable}, {8'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation timeout");
    end

    // ---------------- main sequence ----------------
    initial begin : main_seq
        logic [23:0] snap;
        int h0;
        int r0;
        int k;
        rst        = 1'b1;
        start      = 1'b0;
        chal_base  = '0;
        chal_count = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rst_puf_req", {31'd0, puf_req}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_puf_chal", {24'd0, puf_chal}, 0);
        check("rst_record", {8'd0, out_chal, out_resp, out_unstable}, 0);
        check("rst_state", {29'd0, state_dbg}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Stable PUF, two challenges, exactly 10 handshakes.
        h0 = hs_cnt;
        build_run(8'h10, 2, 0);
        start_run(8'h10, 8'd2);
        wait_done(200, "stable");
        check("stable_handshakes", hs_cnt - h0, 10);

        // Noisy bit0: 3 of 5 and 2 of 5.
        build_run(8'h20, 1, 1);
        start_run(8'h20, 8'd1);
        wait_done(200, "noisy3");
        build_run(8'h20, 1, 2);
        start_run(8'h20, 8'd1);
        wait_done(200, "noisy2");

        // Backpressure for 7 cycles on the first record.
        ready_hold = 1'b1;
        build_run(8'h40, 2, 3);
        start_run(8'h40, 8'd2);
        k = 0;
        while (!out_valid && k < 500) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (!out_valid) fail_now("bp_no_valid");
        snap = {out_chal, out_resp, out_unstable};
        repeat (7) begin
            @(negedge clk);
            #2;
            check("bp_hold", {6'd0, out_valid, puf_req, out_chal, out_resp, out_unstable},
                  {6'd0, 1'b1, 1'b0, snap});
        end
        ready_hold = 1'b0;
        @(negedge clk);
        #2;
        @(negedge clk);
        #2;
        check("bp_accept_next", {31'd0, out_valid}, 0);
        wait_done(500, "bp");

        // Empty run.
        r0 = req_rise;
        start_run(8'h55, 8'd0);
        wait_done(3, "empty");
        check("empty_no_req", req_rise - r0, 0);

        // Challenge wrap.
        build_run(8'hFE, 3, 3);
        start_run(8'hFE, 8'd3);
        wait_done(300, "wrap");

        // Start pulse while busy is ignored.
        build_run(8'h60, 3, 0);
        start_run(8'h60, 8'd3);
        repeat (10) @(negedge clk);
        chal_base  = 8'h99;
        chal_count = 8'd7;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done(300, "midstart");

        // Slow, irregular PUF with random backpressure.
        dly_min    = 3;
        dly_max    = 9;
        rand_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            build_run(8'($urandom), 4, 3);
            start_run(exp_q[0][23:16], 8'd4);
            wait_done(3000, "slow");
        end
        dly_min    = 1;
        dly_max    = 1;
        rand_ready = 1'b0;

        // Reset during the second sample of the first challenge.
        h0 = hs_cnt;
        build_run(8'h10, 2, 0);
        start_run(8'h10, 8'd2);
        k = 0;
        while (!(hs_cnt == h0 + 1 && puf_req) && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (!(hs_cnt == h0 + 1 && puf_req)) fail_now("rst_second_sample_not_reached");
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_drop", {29'd0, puf_req, busy, out_valid}, 0);
        k = 0;
        while (puf_ack && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (puf_ack) fail_now("rst_ack_stuck");
        repeat (2) @(negedge clk);
        #2;
        check("rst_mid_state", {28'd0, done, state_dbg}, 0);
        check("rst_mid_chal", {24'd0, puf_chal}, 0);
        exp_q.delete();
        samp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        build_run(8'h30, 1, 3);
        start_run(8'h30, 8'd1);
        wait_done(200, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
